// File: rtl/ascon_dec_fsm.sv
// ascon_dec_fsm: Moore control FSM for ASCON-128 decryption.
// Steps the shared state datapath and the external round counter through
// initialisation, one associated-data block and NB_CT_BLOCKS ciphertext
// blocks. It finishes by reporting the result of the tag comparison.
//
// Optional feature: define ASCON_DEC_ABORT_EN to add abort_i. When abort_i
// is high in any busy state, the FSM returns to IDLE silently.
//
// Ports:
//   clock_i, reset_i      clock, synchronous active-high reset
//   round_i[3:0]          external round counter value
//   start_i               begin a decryption (sampled in IDLE only)
//   data_valid_i          AD/ciphertext word valid
//   data_ready_o          FSM can consume a word this cycle
//   tag_valid_i           expected tag present in comparator
//   tag_match_i           comparator result
//   input_select_o        load IV||K||N into state
//   ena_xor_up_o          XOR AD word into upper state word
//   ena_replace_o         replace upper state word with ciphertext
//   ena_xor_down_o        lower XOR enable
//   conf_xor_down_o[1:0]  00 key init, 01 domain sep, 10 key final, 11 tag
//   ena_reg_state_o       state register enable
//   init_a_o / init_b_o   load round counter with 0 / 6
//   ena_cpt_o             round counter enable
//   plain_valid_o         plaintext word valid
//   tag_ok_o / tag_fail_o authentication result pulses
//   end_o                 message finished pulse
//   busy_o                high outside IDLE
//   abort_i               (ASCON_DEC_ABORT_EN only) abandon current message
module ascon_dec_fsm #(
  parameter int unsigned NB_CT_BLOCKS = 3,
  parameter logic [3:0]  LAST_RND     = 4'hA
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [3:0] round_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  input  logic       tag_valid_i,
  input  logic       tag_match_i,
`ifdef ASCON_DEC_ABORT_EN
  input  logic       abort_i,
`endif
  output logic       input_select_o,
  output logic       ena_xor_up_o,
  output logic       ena_replace_o,
  output logic       ena_xor_down_o,
  output logic [1:0] conf_xor_down_o,
  output logic       ena_reg_state_o,
  output logic       init_a_o,
  output logic       init_b_o,
  output logic       ena_cpt_o,
  output logic       plain_valid_o,
  output logic       tag_ok_o,
  output logic       tag_fail_o,
  output logic       end_o,
  output logic       busy_o
);

  localparam logic [3:0] LAST_BLK = 4'(NB_CT_BLOCKS - 1);

  typedef enum logic [4:0] {
    IDLE, LOAD, INIT_P, INIT_END, WAIT_A, ABS_A, PERM_A, SEP, WAIT_C,
    DEC, PERM_C, CT_END, FIN_KEY, PERM_F, FIN_TAG, CHECK, PASS, FAIL
  } state_t;

  typedef struct packed {
    logic       data_ready;
    logic       input_select;
    logic       ena_xor_up;
    logic       ena_replace;
    logic       ena_xor_down;
    logic [1:0] conf_xor_down;
    logic       ena_reg_state;
    logic       init_a;
    logic       init_b;
    logic       ena_cpt;
    logic       plain_valid;
    logic       tag_ok;
    logic       tag_fail;
    logic       end_p;
    logic       busy;
  } outs_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  outs_t      outs_q, outs_d;

  // Next-state and block-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:     if (start_i) state_d = LOAD;
      LOAD:     begin state_d = INIT_P; cnt_d = '0; end
      INIT_P:   if (round_i == LAST_RND) state_d = INIT_END;
      INIT_END: state_d = data_valid_i ? ABS_A : WAIT_A;
      WAIT_A:   if (data_valid_i) state_d = ABS_A;
      ABS_A:    state_d = PERM_A;
      PERM_A:   if (round_i == LAST_RND) state_d = SEP;
      SEP:      state_d = data_valid_i ? DEC : WAIT_C;
      WAIT_C:   if (data_valid_i) state_d = DEC;
      DEC: begin
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q < LAST_BLK) ? PERM_C : FIN_KEY;
      end
      PERM_C:   if (round_i == LAST_RND) state_d = CT_END;
      CT_END:   state_d = data_valid_i ? DEC : WAIT_C;
      FIN_KEY:  state_d = PERM_F;
      PERM_F:   if (round_i == LAST_RND) state_d = FIN_TAG;
      FIN_TAG:  state_d = CHECK;
      CHECK:    if (tag_valid_i) state_d = tag_match_i ? PASS : FAIL;
      PASS:     state_d = IDLE;
      FAIL:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
`ifdef ASCON_DEC_ABORT_EN
    if (abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
`endif
  end

  // Output decode of the upcoming state, so registered outputs track state_q.
  // In DEC the counter value seen is the pre-increment one (cnt_d == next cnt_q).
  always_comb begin
    outs_d               = '0;
    outs_d.ena_reg_state = 1'b1;
    outs_d.busy          = 1'b1;
    unique case (state_d)
      IDLE:     begin outs_d.ena_reg_state = 1'b0; outs_d.busy = 1'b0; end
      LOAD:     begin outs_d.init_a = 1'b1; outs_d.ena_cpt = 1'b1; outs_d.input_select = 1'b1; end
      INIT_P:   outs_d.ena_cpt = 1'b1;
      INIT_END: begin
        outs_d.ena_xor_down = 1'b1; outs_d.conf_xor_down = 2'b00;
        outs_d.init_b = 1'b1; outs_d.ena_cpt = 1'b1; outs_d.data_ready = 1'b1;
      end
      WAIT_A:   begin outs_d.ena_reg_state = 1'b0; outs_d.data_ready = 1'b1; end
      ABS_A:    begin outs_d.ena_xor_up = 1'b1; outs_d.ena_cpt = 1'b1; end
      PERM_A:   outs_d.ena_cpt = 1'b1;
      SEP: begin
        outs_d.ena_xor_down = 1'b1; outs_d.conf_xor_down = 2'b01;
        outs_d.init_b = 1'b1; outs_d.ena_cpt = 1'b1; outs_d.data_ready = 1'b1;
      end
      WAIT_C:   begin outs_d.ena_reg_state = 1'b0; outs_d.data_ready = 1'b1; end
      DEC: begin
        outs_d.ena_replace = 1'b1; outs_d.plain_valid = 1'b1;
        outs_d.ena_cpt     = (cnt_d < LAST_BLK);
      end
      PERM_C:   outs_d.ena_cpt = 1'b1;
      CT_END:   begin outs_d.init_b = 1'b1; outs_d.ena_cpt = 1'b1; outs_d.data_ready = 1'b1; end
      FIN_KEY:  begin outs_d.ena_xor_down = 1'b1; outs_d.conf_xor_down = 2'b10; outs_d.init_a = 1'b1; end
      PERM_F:   outs_d.ena_cpt = 1'b1;
      FIN_TAG:  begin outs_d.ena_cpt = 1'b1; outs_d.ena_xor_down = 1'b1; outs_d.conf_xor_down = 2'b11; end
      CHECK:    outs_d.ena_reg_state = 1'b0;
      PASS:     begin outs_d.tag_ok = 1'b1; outs_d.end_p = 1'b1; end
      FAIL:     begin outs_d.tag_fail = 1'b1; outs_d.end_p = 1'b1; end
      default:  outs_d = '0;
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      outs_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      outs_q  <= outs_d;
    end
  end

  assign data_ready_o    = outs_q.data_ready;
  assign input_select_o  = outs_q.input_select;
  assign ena_xor_up_o    = outs_q.ena_xor_up;
  assign ena_replace_o   = outs_q.ena_replace;
  assign ena_xor_down_o  = outs_q.ena_xor_down;
  assign conf_xor_down_o = outs_q.conf_xor_down;
  assign ena_reg_state_o = outs_q.ena_reg_state;
  assign init_a_o        = outs_q.init_a;
  assign init_b_o        = outs_q.init_b;
  assign ena_cpt_o       = outs_q.ena_cpt;
  assign plain_valid_o   = outs_q.plain_valid;
  assign tag_ok_o        = outs_q.tag_ok;
  assign tag_fail_o      = outs_q.tag_fail;
  assign end_o           = outs_q.end_p;
  assign busy_o          = outs_q.busy;

endmodule

// File: tb/tb_ascon_dec_fsm.sv
// tb_ascon_dec_fsm: directed self-checking bench for ascon_dec_fsm with a
// behavioural round counter driven by the FSM's init/enable outputs.
module tb_ascon_dec_fsm;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic [3:0] round_i = 4'd0;
  logic       start_i = 1'b0;
  logic       data_valid_i = 1'b0;
  logic       tag_valid_i = 1'b0;
  logic       tag_match_i = 1'b0;
`ifdef ASCON_DEC_ABORT_EN
  logic       abort_i = 1'b0;
`endif
  logic       data_ready_o, input_select_o, ena_xor_up_o, ena_replace_o;
  logic       ena_xor_down_o, ena_reg_state_o, init_a_o, init_b_o, ena_cpt_o;
  logic       plain_valid_o, tag_ok_o, tag_fail_o, end_o, busy_o;
  logic [1:0] conf_xor_down_o;

  int nvec = 0;
  int nerr = 0;
  int n_plain = 0, n_ok = 0, n_fail = 0, n_end = 0, n_end_lone = 0;
  int b_plain, b_ok, b_fail, b_end, b_lone;
  int seen;

  always #5 clk = ~clk;

  ascon_dec_fsm #(.NB_CT_BLOCKS(3), .LAST_RND(4'hA)) dut (
    .clock_i(clk), .reset_i(reset_i), .round_i(round_i), .start_i(start_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
    .tag_valid_i(tag_valid_i), .tag_match_i(tag_match_i),
`ifdef ASCON_DEC_ABORT_EN
    .abort_i(abort_i),
`endif
    .input_select_o(input_select_o), .ena_xor_up_o(ena_xor_up_o),
    .ena_replace_o(ena_replace_o), .ena_xor_down_o(ena_xor_down_o),
    .conf_xor_down_o(conf_xor_down_o), .ena_reg_state_o(ena_reg_state_o),
    .init_a_o(init_a_o), .init_b_o(init_b_o), .ena_cpt_o(ena_cpt_o),
    .plain_valid_o(plain_valid_o), .tag_ok_o(tag_ok_o), .tag_fail_o(tag_fail_o),
    .end_o(end_o), .busy_o(busy_o)
  );

  // Round counter model: load 0 / load 6 / increment
  always @(posedge clk) begin
    if (reset_i)       round_i <= 4'd0;
    else if (init_a_o) round_i <= 4'd0;
    else if (init_b_o) round_i <= 4'd6;
    else if (ena_cpt_o) round_i <= round_i + 4'd1;
  end

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (plain_valid_o) n_plain++;
    if (tag_ok_o) n_ok++;
    if (tag_fail_o) n_fail++;
    if (end_o) n_end++;
    if (end_o && !(tag_ok_o ^ tag_fail_o)) n_end_lone++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_plain = n_plain; b_ok = n_ok; b_fail = n_fail; b_end = n_end; b_lone = n_end_lone;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  function automatic logic [15:0] all_outs();
    return {data_ready_o, input_select_o, ena_xor_up_o, ena_replace_o, ena_xor_down_o,
            conf_xor_down_o, ena_reg_state_o, init_a_o, init_b_o, ena_cpt_o,
            plain_valid_o, tag_ok_o, tag_fail_o, end_o, busy_o};
  endfunction

  // Run until end_o rises (bounded); leaves sim on the end_o cycle
  task automatic wait_end(input string tag);
    int i;
    for (i = 0; i < 400 && !end_o; i++) tick();
    chk({tag, "_end_seen"}, 32'(end_o), 32'd1);
  endtask

  initial begin
    // 1: reset and idle
    tick(); tick();
    chk("rst_outs", 32'(all_outs()), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    reset_i = 1'b0;
    tick(); tick(); tick();
    chk("idle_hold", 32'(all_outs()), 32'd0);

    // 2: full message, data always valid, tag matches
    data_valid_i = 1'b1; tag_valid_i = 1'b1; tag_match_i = 1'b1;
    snap();
    pulse_start();
    chk("load_outs", 32'({input_select_o, init_a_o, ena_cpt_o, busy_o}), 32'hF);
    wait_end("t2");
    chk("t2_ok_with_end", 32'(tag_ok_o), 32'd1);
    chk("t2_fail_low", 32'(tag_fail_o), 32'd0);
    tick();
    chk("t2_idle_after", 32'(busy_o), 32'd0);
    chk("t2_plain_cnt", 32'(n_plain - b_plain), 32'd3);
    chk("t2_ok_cnt", 32'(n_ok - b_ok), 32'd1);
    chk("t2_end_cnt", 32'(n_end - b_end), 32'd1);
    chk("t2_end_lone", 32'(n_end_lone - b_lone), 32'd0);

    // 3: AD word held off 5 cycles after INIT_END
    data_valid_i = 1'b0;
    pulse_start();
    for (int i = 0; i < 100 && !data_ready_o; i++) tick();
    chk("t3_init_end", 32'({data_ready_o, ena_reg_state_o, ena_xor_down_o, conf_xor_down_o, init_b_o}),
        32'b111001);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_wait_a", 32'({data_ready_o, ena_reg_state_o, ena_cpt_o}), 32'b100);
      chk("t3_round_frozen", 32'(round_i), 32'd6);
    end
    data_valid_i = 1'b1;
    tick();
    chk("t3_abs_a", 32'({ena_xor_up_o, ena_cpt_o, data_ready_o}), 32'b110);
    snap();
    wait_end("t3");
    chk("t3_ok", 32'(tag_ok_o), 32'd1);
    tick();

    // 4: tag delayed 4 cycles, mismatch
    tag_valid_i = 1'b0; tag_match_i = 1'b0;
    snap();
    pulse_start();
    seen = 0;
    for (int i = 0; i < 400 && seen == 0; i++) begin
      if (busy_o && !ena_reg_state_o && !data_ready_o) seen = 1;
      else tick();
    end
    chk("t4_check_reached", 32'(seen), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_check_hold", 32'({busy_o, ena_reg_state_o, end_o}), 32'b100);
    end
    tag_valid_i = 1'b1;
    tick();
    chk("t4_fail_pulse", 32'({tag_fail_o, end_o, tag_ok_o}), 32'b110);
    tick();
    chk("t4_idle", 32'(busy_o), 32'd0);
    chk("t4_fail_cnt", 32'(n_fail - b_fail), 32'd1);
    chk("t4_ok_cnt", 32'(n_ok - b_ok), 32'd0);

    // 5: reset during PERM_C after block 2, then restart
    tag_match_i = 1'b1;
    snap();
    pulse_start();
    seen = 0;
    for (int i = 0; i < 400 && seen < 2; i++) begin
      tick();
      if (plain_valid_o) seen++;
    end
    chk("t5_two_blocks", 32'(seen), 32'd2);
    tick();
    chk("t5_perm_c", 32'({ena_cpt_o, data_ready_o, plain_valid_o}), 32'b100);
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("t5_rst_outs", 32'(all_outs()), 32'd0);
    tick(); tick(); tick();
    chk("t5_no_end", 32'(n_end - b_end), 32'd0);
    snap();
    pulse_start();
    wait_end("t5");
    tick();
    chk("t5_plain_cnt", 32'(n_plain - b_plain), 32'd3);
    chk("t5_ok_cnt", 32'(n_ok - b_ok), 32'd1);

`ifdef ASCON_DEC_ABORT_EN
    // 6: abort while waiting for ciphertext
    snap();
    pulse_start();
    for (int i = 0; i < 100 && !ena_xor_up_o; i++) tick();
    chk("t6_abs_a", 32'(ena_xor_up_o), 32'd1);
    data_valid_i = 1'b0;
    for (int i = 0; i < 100 && !data_ready_o; i++) tick();
    tick();
    chk("t6_wait_c", 32'({data_ready_o, ena_reg_state_o}), 32'b10);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("t6_abort_idle", 32'(all_outs()), 32'd0);
    tick(); tick();
    chk("t6_no_pulses", 32'((n_end - b_end) + (n_ok - b_ok) + (n_fail - b_fail)), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
